// File: rtl/reg_write_arbiter_if.sv
// Bus between four register-write requesters and the write arbiter.
// The slave side is the arbiter; the master side drives requests and observes grants.
interface reg_write_arbiter_if #(
   parameter int n  = 16,
   parameter int AW = 3
);
   logic [3:0]      req;
   logic [4*AW-1:0] req_addr;
   logic [4*n-1:0]  req_data;
   logic            clr_all;
   logic [3:0]      gnt;
   logic            wr_en;
   logic [AW-1:0]   wr_addr;
   logic [n-1:0]    wr_data;
   logic            busy;

   modport master (
      output req, req_addr, req_data, clr_all,
      input  gnt, wr_en, wr_addr, wr_data, busy
   );

   modport slave (
      input  req, req_addr, req_data, clr_all,
      output gnt, wr_en, wr_addr, wr_data, busy
   );
endinterface

// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter for four register-bank writers, with a bank-clear walk
// that writes zero to every address when clr_all is seen.
module reg_write_arbiter #(
   parameter int n  = 16,
   parameter int AW = 3
) (
   input  logic                 clk,
   input  logic                 reset,
   reg_write_arbiter_if.slave   bus
);

   typedef enum logic {ARB, CLEAR} state_e;

   localparam logic [AW-1:0] LAST_ADDR = '1;

   state_e          state_q, state_d;
   logic [1:0]      ptr_q, ptr_d;
   logic [AW-1:0]   cnt_q, cnt_d;
   logic [3:0]      gnt_q, gnt_d;
   logic            wr_en_q, wr_en_d;
   logic [AW-1:0]   wr_addr_q, wr_addr_d;
   logic [n-1:0]    wr_data_q, wr_data_d;
   logic            busy_q, busy_d;

   logic [AW-1:0]   addr_arr [4];
   logic [n-1:0]    data_arr [4];
   logic [3:0]      elig;
   logic            found;
   logic [1:0]      win;
   logic [1:0]      idx;

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_unpack
         assign addr_arr[gi] = bus.req_addr[gi*AW +: AW];
         assign data_arr[gi] = bus.req_data[gi*n +: n];
      end
   endgenerate

   // A requester granted last cycle sits out this edge.
   assign elig = bus.req & ~gnt_q;

   always_comb begin
      found = 1'b0;
      win   = 2'd0;
      idx   = 2'd0;
      for (int k = 0; k < 4; k++) begin
         idx = ptr_q + 2'(k);
         if (!found && elig[idx]) begin
            found = 1'b1;
            win   = idx;
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      cnt_d     = cnt_q;
      gnt_d     = 4'b0000;
      wr_en_d   = 1'b0;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
      busy_d    = 1'b0;

      case (state_q)
         ARB: begin
            if (bus.clr_all) begin
               state_d = CLEAR;
               cnt_d   = '0;
               busy_d  = 1'b1;
            end else if (found) begin
               gnt_d     = 4'b0001 << win;
               wr_en_d   = 1'b1;
               wr_addr_d = addr_arr[win];
               wr_data_d = data_arr[win];
               ptr_d     = win + 2'd1;
            end
         end
         CLEAR: begin
            // busy stays high through the edge issuing the last address.
            wr_en_d   = 1'b1;
            wr_addr_d = cnt_q;
            wr_data_d = '0;
            busy_d    = 1'b1;
            cnt_d     = cnt_q + AW'(1);
            if (cnt_q == LAST_ADDR) begin
               state_d = ARB;
            end
         end
         default: begin
            state_d = ARB;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= ARB;
         ptr_q     <= 2'd0;
         cnt_q     <= '0;
         gnt_q     <= 4'b0000;
         wr_en_q   <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         cnt_q     <= cnt_d;
         gnt_q     <= gnt_d;
         wr_en_q   <= wr_en_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
         busy_q    <= busy_d;
      end
   end

   assign bus.gnt     = gnt_q;
   assign bus.wr_en   = wr_en_q;
   assign bus.wr_addr = wr_addr_q;
   assign bus.wr_data = wr_data_q;
   assign bus.busy    = busy_q;

endmodule
